// File: rtl/fios_operand_server_if.sv
// Operand/result handshake between the FIOS operand server (slave side) and the
// multiplier control (master side).
interface fios_operand_server_if #(
    parameter int PE_NB = 8
);
    logic                mm_start_o;
    logic [PE_NB*17-1:0] a_o;
    logic [16:0]         b_o;
    logic [16:0]         p_o;
    logic                a_shift_i;
    logic                b_fetch_i;
    logic                p_fetch_i;
    logic                RES_push_i;
    logic [16:0]         RES_i;
    logic                done_i;

    modport master (
        input  mm_start_o, a_o, b_o, p_o,
        output a_shift_i, b_fetch_i, p_fetch_i, RES_push_i, RES_i, done_i
    );

    modport slave (
        output mm_start_o, a_o, b_o, p_o,
        input  a_shift_i, b_fetch_i, p_fetch_i, RES_push_i, RES_i, done_i
    );
endinterface

// File: rtl/fios_operand_server.sv
// FIOS operand server: serves A/B/P operands to the multiplier and collects its RES words.
// Optional protocol checker enabled by defining FIOS_OPERAND_SERVER_CHECK_EN (drives err_o).
module fios_operand_server #(
    parameter  int s     = 8,
    parameter  int PE_NB = 8,
    localparam int AW    = $clog2(s)
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 wr_en_i,
    input  logic [1:0]           wr_sel_i,
    input  logic [AW-1:0]        wr_addr_i,
    input  logic [16:0]          wr_data_i,
    input  logic                 go_i,
    output logic                 busy_o,
    output logic                 res_valid_o,
    input  logic [AW-1:0]        rd_addr_i,
    output logic [16:0]          rd_data_o,
    output logic                 err_o,
    fios_operand_server_if.slave mm
);
    localparam int PW = $clog2(s + 1);
    localparam int NG = (s + PE_NB - 1) / PE_NB;
    localparam int GW = (NG > 1) ? $clog2(NG) : 1;
    localparam logic [AW:0]   S_EXT  = (AW+1)'(s);
    localparam logic [PW-1:0] S_PTR  = PW'(s);
    localparam logic [AW-1:0] LAST_W = AW'(s - 1);
    localparam logic [GW-1:0] LAST_G = GW'(NG - 1);

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_e;

    state_e              state_q;
    logic [16:0]         aMem   [s];
    logic [16:0]         bMem   [s];
    logic [16:0]         pMem   [s];
    logic [16:0]         resMem [s];
    logic [PE_NB*17-1:0] aWin_q, aWin_d;
    logic [16:0]         b_q, p_q, rdData_q, rdData_d;
    logic [GW-1:0]       grp_q, grpNext, grpTgt;
    logic [AW-1:0]       bPtr_q, pPtr_q, bPtrNext, pPtrNext;
    logic [PW-1:0]       resPtr_q, resPtr_d;
    logic                busy_q, resValid_q, mmStart_q;
    logic                hostWr, resStore;
    int                  idx;

    always_comb begin
        hostWr   = !reset_i && (state_q == IDLE) && wr_en_i && ({1'b0, wr_addr_i} < S_EXT);
        resStore = !reset_i && (state_q == RUN) && mm.RES_push_i && (resPtr_q != S_PTR);
        resPtr_d = resPtr_q + PW'(resStore);
        bPtrNext = (bPtr_q == LAST_W) ? '0 : bPtr_q + 1'b1;
        pPtrNext = (pPtr_q == LAST_W) ? '0 : pPtr_q + 1'b1;
        grpNext  = (grp_q == LAST_G) ? '0 : grp_q + 1'b1;
        rdData_d = ({1'b0, rd_addr_i} < S_EXT) ? resMem[rd_addr_i] : '0;
    end

    // The window always targets the group that will be presented next:
    // group 0 when arming, the following group while running.
    always_comb begin
        grpTgt = (state_q == RUN) ? grpNext : '0;
        aWin_d = '0;
        idx    = 0;
        for (int j = 0; j < PE_NB; j++) begin
            idx = int'(grpTgt) * PE_NB + j;
            if (idx < s) begin
                aWin_d[j*17 +: 17] = aMem[idx[AW-1:0]];
            end
        end
    end

    // Operand and result storage has no reset so operands survive a mid-run reset.
    always_ff @(posedge clock_i) begin
        if (hostWr) begin
            case (wr_sel_i)
                2'd0:    aMem[wr_addr_i] <= wr_data_i;
                2'd1:    bMem[wr_addr_i] <= wr_data_i;
                2'd2:    pMem[wr_addr_i] <= wr_data_i;
                default: ;
            endcase
        end
        if (resStore) begin
            resMem[resPtr_q[AW-1:0]] <= mm.RES_i;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q    <= IDLE;
            busy_q     <= 1'b0;
            resValid_q <= 1'b0;
            mmStart_q  <= 1'b0;
            aWin_q     <= '0;
            b_q        <= '0;
            p_q        <= '0;
            grp_q      <= '0;
            bPtr_q     <= '0;
            pPtr_q     <= '0;
            resPtr_q   <= '0;
            rdData_q   <= '0;
        end else begin
            mmStart_q <= 1'b0;
            rdData_q  <= rdData_d;
            case (state_q)
                IDLE: begin
                    if (go_i) begin
                        state_q <= ARM;
                        busy_q  <= 1'b1;
                    end
                end
                ARM: begin
                    state_q    <= RUN;
                    mmStart_q  <= 1'b1;
                    aWin_q     <= aWin_d;
                    b_q        <= bMem[0];
                    p_q        <= pMem[0];
                    grp_q      <= '0;
                    bPtr_q     <= '0;
                    pPtr_q     <= '0;
                    resPtr_q   <= '0;
                    resValid_q <= 1'b0;
                end
                RUN: begin
                    if (mm.a_shift_i) begin
                        grp_q  <= grpNext;
                        aWin_q <= aWin_d;
                    end
                    if (mm.b_fetch_i) begin
                        bPtr_q <= bPtrNext;
                        b_q    <= bMem[bPtrNext];
                    end
                    if (mm.p_fetch_i) begin
                        pPtr_q <= pPtrNext;
                        p_q    <= pMem[pPtrNext];
                    end
                    resPtr_q <= resPtr_d;
                    if (mm.done_i) begin
                        state_q    <= DONE;
                        busy_q     <= 1'b0;
                        resValid_q <= 1'b1;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FIOS_OPERAND_SERVER_CHECK_EN
    logic err_q, errHit, inRun;

    // A done is judged against the pointer after any coincident push has landed.
    always_comb begin
        inRun  = (state_q == RUN);
        errHit = (inRun && mm.RES_push_i && (resPtr_q == S_PTR))
               || (inRun && mm.done_i && (resPtr_d != S_PTR))
               || (!inRun && (mm.a_shift_i || mm.b_fetch_i || mm.p_fetch_i
                              || mm.RES_push_i || mm.done_i))
               || (inRun && wr_en_i);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            err_q <= 1'b0;
        end else if (errHit) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign busy_o        = busy_q;
    assign res_valid_o   = resValid_q;
    assign rd_data_o     = rdData_q;
    assign mm.mm_start_o = mmStart_q;
    assign mm.a_o        = aWin_q;
    assign mm.b_o        = b_q;
    assign mm.p_o        = p_q;
endmodule

// File: tb/tb_fios_operand_server.sv
// Testbench for fios_operand_server: a PE_NB=8 and a PE_NB=3 instance share all host
// and multiplier-side stimulus so both window widths are exercised in one run.
module tb_fios_operand_server;
    localparam int S = 8;

`ifdef FIOS_OPERAND_SERVER_CHECK_EN
    localparam logic CHECK_ON = 1'b1;
`else
    localparam logic CHECK_ON = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        wrEn = 1'b0, go = 1'b0;
    logic        aShift = 1'b0, bFetch = 1'b0, pFetch = 1'b0, resPush = 1'b0, done = 1'b0;
    logic [1:0]  wrSel = '0;
    logic [2:0]  wrAddr = '0, rdAddr = '0;
    logic [16:0] wrData = '0, resIn = '0;

    logic        busy8, valid8, err8, busy3, valid3, err3;
    logic [16:0] rd8, rd3;

    int nCompared = 0;
    int nFailed   = 0;

    always #5 clock = ~clock;

    fios_operand_server_if #(.PE_NB(8)) mm8 ();
    fios_operand_server_if #(.PE_NB(3)) mm3 ();

    assign mm8.a_shift_i  = aShift;
    assign mm8.b_fetch_i  = bFetch;
    assign mm8.p_fetch_i  = pFetch;
    assign mm8.RES_push_i = resPush;
    assign mm8.RES_i      = resIn;
    assign mm8.done_i     = done;
    assign mm3.a_shift_i  = aShift;
    assign mm3.b_fetch_i  = bFetch;
    assign mm3.p_fetch_i  = pFetch;
    assign mm3.RES_push_i = resPush;
    assign mm3.RES_i      = resIn;
    assign mm3.done_i     = done;

    fios_operand_server #(.s(S), .PE_NB(8)) dut8 (
        .clock_i(clock), .reset_i(reset), .wr_en_i(wrEn), .wr_sel_i(wrSel),
        .wr_addr_i(wrAddr), .wr_data_i(wrData), .go_i(go), .busy_o(busy8),
        .res_valid_o(valid8), .rd_addr_i(rdAddr), .rd_data_o(rd8), .err_o(err8),
        .mm(mm8.slave)
    );

    fios_operand_server #(.s(S), .PE_NB(3)) dut3 (
        .clock_i(clock), .reset_i(reset), .wr_en_i(wrEn), .wr_sel_i(wrSel),
        .wr_addr_i(wrAddr), .wr_data_i(wrData), .go_i(go), .busy_o(busy3),
        .res_valid_o(valid3), .rd_addr_i(rdAddr), .rd_data_o(rd3), .err_o(err3),
        .mm(mm3.slave)
    );

    // Reference model: operand arrays, result array and the handshake rules
    logic [16:0]  mA [S];
    logic [16:0]  mB [S];
    logic [16:0]  mP [S];
    logic [16:0]  mR [S];
    bit           rKnown [S];
    bit           live = 0, armed = 0, running = 0, finishing = 0, rdKnown = 0;
    logic         expBusy, expValid, expStart, expErr;
    logic [135:0] expA8, expA3;
    logic [16:0]  expB, expP, expRd;
    int           grp8, grp3, bp, pp, rp;

    function automatic logic [135:0] window(input int k, input int pe);
        logic [135:0] w = '0;
        for (int j = 0; j < pe; j++) begin
            if (k * pe + j < S) w[j*17 +: 17] = mA[k*pe + j];
        end
        return w;
    endfunction

    always @(posedge clock) begin
        if (reset) begin
            live = 1; armed = 0; running = 0; finishing = 0;
            expBusy = 0; expValid = 0; expStart = 0; expErr = 0;
            expA8 = '0; expA3 = '0; expB = '0; expP = '0; expRd = '0; rdKnown = 1;
            grp8 = 0; grp3 = 0; bp = 0; pp = 0; rp = 0;
        end else begin
            rdKnown = rKnown[rdAddr];
            expRd   = mR[rdAddr];
            if (CHECK_ON) begin
                if (running && resPush && rp == S) expErr = 1;
                if (running && done && (rp + ((resPush && rp < S) ? 1 : 0)) != S) expErr = 1;
                if (!running && (aShift || bFetch || pFetch || resPush || done)) expErr = 1;
                if (running && wrEn) expErr = 1;
            end
            expStart = 0;
            if (finishing) begin
                finishing = 0;
            end else if (armed) begin
                armed = 0; running = 1; expStart = 1; expValid = 0;
                grp8 = 0; grp3 = 0; bp = 0; pp = 0; rp = 0;
                expA8 = window(0, 8); expA3 = window(0, 3);
                expB = mB[0]; expP = mP[0];
            end else if (running) begin
                if (aShift) begin
                    grp8 = (grp8 + 1) % ((S + 7) / 8);
                    grp3 = (grp3 + 1) % ((S + 2) / 3);
                    expA8 = window(grp8, 8);
                    expA3 = window(grp3, 3);
                end
                if (bFetch) begin bp = (bp + 1) % S; expB = mB[bp]; end
                if (pFetch) begin pp = (pp + 1) % S; expP = mP[pp]; end
                if (resPush && rp < S) begin mR[rp] = resIn; rKnown[rp] = 1; rp++; end
                if (done) begin running = 0; finishing = 1; expBusy = 0; expValid = 1; end
            end else begin
                if (wrEn) begin
                    case (wrSel)
                        2'd0: mA[wrAddr] = wrData;
                        2'd1: mB[wrAddr] = wrData;
                        2'd2: mP[wrAddr] = wrData;
                        default: ;
                    endcase
                end
                if (go) begin armed = 1; expBusy = 1; end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [135:0] act, input logic [135:0] exp);
        nCompared++;
        if (act !== exp) begin
            nFailed++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (live) begin
            checkOutput("busy8", 136'(busy8), 136'(expBusy));
            checkOutput("busy3", 136'(busy3), 136'(expBusy));
            checkOutput("valid8", 136'(valid8), 136'(expValid));
            checkOutput("valid3", 136'(valid3), 136'(expValid));
            checkOutput("start8", 136'(mm8.mm_start_o), 136'(expStart));
            checkOutput("err8", 136'(err8), 136'(expErr));
            checkOutput("err3", 136'(err3), 136'(expErr));
            checkOutput("a8", mm8.a_o, expA8);
            checkOutput("a3", 136'(mm3.a_o), expA3);
            checkOutput("b8", 136'(mm8.b_o), 136'(expB));
            checkOutput("p8", 136'(mm8.p_o), 136'(expP));
            checkOutput("b3", 136'(mm3.b_o), 136'(expB));
            if (rdKnown) begin
                checkOutput("rd8", 136'(rd8), 136'(expRd));
                checkOutput("rd3", 136'(rd3), 136'(expRd));
            end
        end
    end

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clock);
            #1;
            wrEn = 0; go = 0; aShift = 0; bFetch = 0; pFetch = 0; resPush = 0; done = 0;
        end
    endtask

    task automatic writeWord(input logic [1:0] sel, input int addr, input logic [16:0] data, input logic withGo);
        wrEn = 1; wrSel = sel; wrAddr = 3'(addr); wrData = data; go = withGo;
        applyStimulus(1);
    endtask

    logic [16:0] bSeq [10] = '{17'h11, 17'h12, 17'h13, 17'h14, 17'h15,
                               17'h16, 17'h17, 17'h10, 17'h11, 17'h12};
    logic [50:0] a3Seq [3] = '{{17'd6, 17'd5, 17'd4}, {17'd0, 17'd8, 17'd7}, {17'd3, 17'd2, 17'd1}};

    initial begin
        reset = 1;
        applyStimulus(2);
        reset = 0;
        checkOutput("rst_busy", 136'(busy8), 136'(1'b0));
        checkOutput("rst_valid", 136'(valid8), 136'(1'b0));
        checkOutput("rst_b", 136'(mm8.b_o), 136'(17'h0));
        checkOutput("rst_a", mm8.a_o, 136'(0));

        for (int i = 0; i < S; i++) writeWord(2'd0, i, 17'(i + 1), 1'b0);
        for (int i = 0; i < S; i++) writeWord(2'd1, i, 17'(16 + i), 1'b0);
        writeWord(2'd3, 0, 17'h155, 1'b0);
        for (int i = 0; i < S - 1; i++) writeWord(2'd2, i, 17'h1FFFF, 1'b0);
        writeWord(2'd2, S - 1, 17'h1FFFF, 1'b1);

        checkOutput("go_busy_c1", 136'(busy8), 136'(1'b1));
        checkOutput("go_start_c1", 136'(mm8.mm_start_o), 136'(1'b0));
        applyStimulus(1);
        checkOutput("start_c2", 136'(mm8.mm_start_o), 136'(1'b1));
        checkOutput("a8_word0", 136'(mm8.a_o[16:0]), 136'(17'd1));
        checkOutput("a8_word7", 136'(mm8.a_o[135:119]), 136'(17'd8));
        checkOutput("b_first", 136'(mm8.b_o), 136'(17'h10));
        checkOutput("p_first", 136'(mm8.p_o), 136'(17'h1FFFF));
        go = 1;
        applyStimulus(1);
        checkOutput("start_c3", 136'(mm8.mm_start_o), 136'(1'b0));
        checkOutput("busy_run", 136'(busy8), 136'(1'b1));

        for (int i = 0; i < 10; i++) begin
            bFetch = 1;
            applyStimulus(1);
            checkOutput("b_seq", 136'(mm8.b_o), 136'(bSeq[i]));
        end
        pFetch = 1;
        applyStimulus(1);
        for (int i = 0; i < 3; i++) begin
            aShift = 1;
            applyStimulus(1);
            checkOutput("a3_win", 136'(mm3.a_o), 136'(a3Seq[i]));
        end

        for (int i = 0; i < S; i++) begin
            resPush = 1; resIn = 17'(17'hA0 + i); done = (i == S - 1);
            applyStimulus(1);
        end
        checkOutput("done_valid", 136'(valid8), 136'(1'b1));
        checkOutput("done_busy", 136'(busy8), 136'(1'b0));
        checkOutput("done_err", 136'(err8), 136'(1'b0));
        rdAddr = 3'd7;
        applyStimulus(1);
        checkOutput("rd_7", 136'(rd8), 136'(17'hA7));
        rdAddr = 3'd0;
        applyStimulus(1);
        checkOutput("rd_0", 136'(rd8), 136'(17'hA0));

        go = 1;
        applyStimulus(2);
        checkOutput("valid_cleared", 136'(valid8), 136'(1'b0));
        for (int i = 0; i < S - 1; i++) begin
            resPush = 1; resIn = 17'(17'hB0 + i);
            applyStimulus(1);
        end
        done = 1;
        applyStimulus(1);
        checkOutput("short_err", 136'(err8), 136'(CHECK_ON));
        rdAddr = 3'd6;
        applyStimulus(1);
        checkOutput("rd_short6", 136'(rd8), 136'(17'hB6));
        rdAddr = 3'd7;
        applyStimulus(1);
        checkOutput("rd_short7", 136'(rd8), 136'(17'hA7));

        go = 1;
        applyStimulus(2);
        checkOutput("err_sticky", 136'(err8), 136'(CHECK_ON));
        for (int i = 0; i < S + 1; i++) begin
            resPush = 1; resIn = 17'(17'hC0 + i);
            applyStimulus(1);
        end
        done = 1;
        applyStimulus(1);
        rdAddr = 3'd7;
        applyStimulus(1);
        checkOutput("rd_saturate", 136'(rd8), 136'(17'hC7));
        bFetch = 1; aShift = 1; pFetch = 1;
        applyStimulus(1);
        checkOutput("idle_fetch_ignored", 136'(mm8.b_o), 136'(17'h10));

        go = 1;
        applyStimulus(2);
        bFetch = 1; applyStimulus(1);
        bFetch = 1; aShift = 1; applyStimulus(1);
        for (int i = 0; i < 3; i++) begin
            resPush = 1; resIn = 17'(17'hD0 + i);
            applyStimulus(1);
        end
        reset = 1;
        applyStimulus(1);
        reset = 0;
        checkOutput("midrst_busy", 136'(busy8), 136'(1'b0));
        checkOutput("midrst_valid", 136'(valid8), 136'(1'b0));
        checkOutput("midrst_err", 136'(err8), 136'(1'b0));
        go = 1;
        applyStimulus(2);
        checkOutput("rerun_b", 136'(mm8.b_o), 136'(17'h10));
        checkOutput("rerun_a3", 136'(mm3.a_o), 136'(a3Seq[2]));
        checkOutput("rerun_a8_w7", 136'(mm8.a_o[135:119]), 136'(17'd8));
        checkOutput("rerun_p", 136'(mm8.p_o), 136'(17'h1FFFF));
        for (int i = 0; i < S; i++) begin
            resPush = 1; resIn = 17'(17'hE0 + i); done = (i == S - 1);
            applyStimulus(1);
        end
        applyStimulus(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end
endmodule

// File: doc/fios_operand_server.md
Name: fios_operand_server

Overview:
- Responder side of the FIOS multiplier operand/result handshake.
- Holds the A, B and P operand words and serves them to the multiplier control: A as a PE-wide shifting window, B and P as word streams.
- Collects the RES words the multiplier pushes and exposes them to a host read port once done is seen.
- Sits between the host/register file and the FIOS multiplier top.

Parameters:
s, 8, number of 17-bit words per operand.
PE_NB, 8, number of PEs; width of the A window in words (FOLD builds pass fewer than s).
AW, $clog2(s), host word-address width (derived, localparam).

Ports:
clock_i  in  1  clock.
reset_i  in  1  reset; synchronous, active-high.
wr_en_i  in  1  host operand write strobe.
wr_sel_i  in  2  0=A, 1=B, 2=P, 3=ignored.
wr_addr_i  in  AW  word index.
wr_data_i  in  17  word data.
go_i  in  1  host request to start a multiplication.
busy_o  out  1  high from accepted go_i until done_i.
res_valid_o  out  1  result buffer complete and readable.
rd_addr_i  in  AW  result word index.
rd_data_o  out  17  result word, registered.
err_o  out  1  sticky protocol error (see Optional Feature).
mm_start_o  out  1  one-cycle start pulse to the multiplier.
a_o  out  PE_NB*17  A window; word j is at bits [17j+16:17j].
b_o  out  17  current B word.
p_o  out  17  current P word.
a_shift_i  in  1  advance A window.
b_fetch_i  in  1  advance B pointer.
p_fetch_i  in  1  advance P pointer.
RES_push_i  in  1  RES_i is valid this cycle.
RES_i  in  17  result word.
done_i  in  1  multiplication complete.

Behaviour:
- Reset values: all outputs 0; state IDLE; all pointers 0. Operand and result memories are not cleared.
- FSM states:
  - IDLE: wr_en_i writes mem[wr_sel_i][wr_addr_i]; addresses >= s are dropped. go_i -> ARM.
  - ARM (1 cycle): load registered a_o/b_o/p_o from group 0 / word 0; clear res_ptr and res_valid_o. -> RUN, with mm_start_o=1 in that cycle.
  - RUN: busy_o=1. Host writes are ignored. done_i -> DONE.
  - DONE (1 cycle): busy_o=0, res_valid_o=1. -> IDLE.
- Latencies:
  - go_i to mm_start_o: 2 cycles (go_i at cycle t, ARM at t+1, mm_start_o at t+2).
  - go_i to busy_o: 1 cycle.
- A window:
  - Group k presents A[k*PE_NB+j] for j=0..PE_NB-1; indices >= s read as 0.
  - a_shift_i advances k one cycle later.
  - After group ceil(s/PE_NB)-1, k wraps to 0.
- B and P:
  - b_o = B[b_ptr]; b_fetch_i increments b_ptr, and the new word appears next cycle.
  - b_ptr wraps s-1 -> 0 (B is re-streamed every outer iteration). P identical with p_ptr.
  - Fetch or shift outside RUN: ignored.
- Results:
  - RES_push_i in RUN writes RES_i to res_mem[res_ptr]; res_ptr++.
  - res_ptr saturates at s; extra pushes are dropped.
  - RES_push_i and done_i in the same cycle: the word is stored first, then DONE.
- res_valid_o holds until the next go_i is accepted. rd_data_o = res_mem[rd_addr_i] one cycle after rd_addr_i; readable in any state.
- go_i outside IDLE: ignored. wr_en_i and go_i in the same IDLE cycle: the write is committed, then the block arms.
- Reset mid-RUN: return to IDLE, busy_o=0, res_valid_o=0, pointers 0, operands retained.

Optional Feature:
- Macro FIOS_OPERAND_SERVER_CHECK_EN.
- Defined: err_o is set, and stays sticky until reset, on any of the following:
  - RES_push_i when res_ptr==s;
  - done_i with res_ptr!=s;
  - a_shift_i/b_fetch_i/p_fetch_i/RES_push_i/done_i outside RUN;
  - wr_en_i during RUN.
- Not defined: err_o is tied 0 and no check logic is built.

Test Plan:
- Load A=1..8, B=0x10..0x17, P=0x1FFFF x8; pulse go_i at cycle 0 -> busy_o=1 at cycle 1, mm_start_o single pulse at cycle 2; a_o word0=1, word7=8; b_o=0x10, p_o=0x1FFFF.
- In RUN, 10 b_fetch_i pulses -> b_o sequence 0x11..0x17, 0x10, 0x11, 0x12 (wrap after 8).
- PE_NB=3, s=8: a_shift_i x3 -> windows {4,5,6}, {7,8,0}, then {1,2,3} (wrap, zero fill).
- Push RES 0xA0..0xA7, with done_i coincident with the last push -> res_valid_o=1, busy_o=0; rd_addr_i=7 gives rd_data_o=0xA7 one cycle later; err_o=0.
- With FIOS_OPERAND_SERVER_CHECK_EN: 7 pushes then done_i -> err_o=1 and stays 1 after the next go_i. Without the macro: err_o=0.
- Assert reset_i mid-RUN after 3 pushes -> next cycle busy_o=0, res_valid_o=0; a new go_i gives b_o=B[0] and a_o=group 0, with operands intact.
